// File: rtl/sound_arbiter_if.sv
// sound_arbiter_if: requester-side and engine-side signals of the sound arbiter.
// master: the requesters plus the Sound engine. slave: the arbiter.
interface sound_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int NOTE_BITS = 3,
    parameter int OCT_BITS  = 3,
    parameter int LEN_BITS  = 3
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*NOTE_BITS-1:0] note_in;
    logic [NUM_REQ*OCT_BITS-1:0]  oct_in;
    logic [NUM_REQ*LEN_BITS-1:0]  len_in;
    logic                         abort;
    logic [NUM_REQ-1:0]           gnt;
    logic [OWN_W-1:0]             owner;
    logic                         busy;
    logic                         done;
    logic [1:0]                   status;
    logic                         snd_en;
    logic [NOTE_BITS-1:0]         snd_note;
    logic [OCT_BITS-1:0]          snd_oct;
    logic [LEN_BITS-1:0]          snd_len;
    logic                         snd_over;

    modport master (
        output req, note_in, oct_in, len_in, abort, snd_over,
        input  gnt, owner, busy, done, status, snd_en, snd_note, snd_oct, snd_len
    );

    modport slave (
        input  req, note_in, oct_in, len_in, abort, snd_over,
        output gnt, owner, busy, done, status, snd_en, snd_note, snd_oct, snd_len
    );
endinterface

// File: rtl/sound_arbiter.sv
// sound_arbiter: shares the single note/tone engine between NUM_REQ requesters.
// Grants one note at a time, latches its fields, drives the engine enable, waits
// for the engine to finish (or abort/watchdog), then holds a silent gap.
// Build option: define ROUND_ROBIN_EN for rotating priority; default is fixed
// priority with the lowest index winning.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | engine free, arbitrating pending requests
// S_START | enable raised, waiting for the engine to drop snd_over
// S_PLAY  | note sounding, waiting for snd_over to rise again
// S_GAP   | enable low, silent down-count before the next grant
module sound_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NOTE_BITS  = 3,
    parameter int OCT_BITS   = 3,
    parameter int LEN_BITS   = 3,
    parameter int GAP_CYCLES = 100000,
    parameter int MAX_CYCLES = 2**28-1
) (
    input  logic           clk,
    input  logic           rst_n,
    sound_arbiter_if.slave bus
);
    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(MAX_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MAX_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ABORT = 2'b01;
    localparam logic [1:0] ST_TMO   = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_START, S_PLAY, S_GAP} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [1:0]           status_q, status_d;
    logic                 snd_en_q, snd_en_d;
    logic [NOTE_BITS-1:0] snd_note_q, snd_note_d;
    logic [OCT_BITS-1:0]  snd_oct_q, snd_oct_d;
    logic [LEN_BITS-1:0]  snd_len_q, snd_len_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
`ifdef ROUND_ROBIN_EN
    logic [OWN_W-1:0]     ptr_q, ptr_d;
`endif

    logic [NOTE_BITS-1:0] note_arr [NUM_REQ];
    logic [OCT_BITS-1:0]  oct_arr  [NUM_REQ];
    logic [LEN_BITS-1:0]  len_arr  [NUM_REQ];
    logic [OWN_W-1:0]     win;
    logic                 finish;
    logic [1:0]           fin_status;

    // Unpack the per-requester note fields.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            note_arr[k] = bus.note_in[k*NOTE_BITS +: NOTE_BITS];
            oct_arr[k]  = bus.oct_in[k*OCT_BITS +: OCT_BITS];
            len_arr[k]  = bus.len_in[k*LEN_BITS +: LEN_BITS];
        end
    end

    // Pick the winner; the scan runs backwards so the last hit is the highest priority.
    always_comb begin
        win = '0;
`ifdef ROUND_ROBIN_EN
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req[OWN_W'((int'(ptr_q) + k) % NUM_REQ)])
                win = OWN_W'((int'(ptr_q) + k) % NUM_REQ);
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[OWN_W'(k)]) win = OWN_W'(k);
        end
`endif
    end

    // Next-state and next-output logic; engine finish outranks abort outranks watchdog.
    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        done_d     = 1'b0;
        owner_d    = owner_q;
        status_d   = status_q;
        snd_en_d   = snd_en_q;
        snd_note_d = snd_note_q;
        snd_oct_d  = snd_oct_q;
        snd_len_d  = snd_len_q;
        wdog_d     = wdog_q;
        gap_d      = gap_q;
`ifdef ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        finish     = 1'b0;
        fin_status = ST_OK;
        unique case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    gnt_d[win] = 1'b1;
                    owner_d    = win;
                    snd_note_d = note_arr[win];
                    snd_oct_d  = oct_arr[win];
                    snd_len_d  = len_arr[win];
                    snd_en_d   = 1'b1;
                    wdog_d     = '0;
                    state_d    = S_START;
`ifdef ROUND_ROBIN_EN
                    ptr_d      = win;
`endif
                end
            end
            S_START, S_PLAY: begin
                if (wdog_q < WD_LAST) wdog_d = wdog_q + 1'b1;
                if (state_q == S_PLAY && bus.snd_over) begin
                    finish     = 1'b1;
                    fin_status = ST_OK;
                end else if (bus.abort) begin
                    finish     = 1'b1;
                    fin_status = ST_ABORT;
                end else if (wdog_q >= WD_LAST) begin
                    finish     = 1'b1;
                    fin_status = ST_TMO;
                end else if (state_q == S_START && !bus.snd_over) begin
                    state_d = S_PLAY;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (finish) begin
            done_d   = 1'b1;
            status_d = fin_status;
            snd_en_d = 1'b0;
            gap_d    = GAP_LAST;
            state_d  = S_GAP;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= ST_OK;
            snd_en_q   <= 1'b0;
            snd_note_q <= '0;
            snd_oct_q  <= '0;
            snd_len_q  <= '0;
            wdog_q     <= '0;
            gap_q      <= '0;
`ifdef ROUND_ROBIN_EN
            ptr_q      <= OWN_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            status_q   <= status_d;
            snd_en_q   <= snd_en_d;
            snd_note_q <= snd_note_d;
            snd_oct_q  <= snd_oct_d;
            snd_len_q  <= snd_len_d;
            wdog_q     <= wdog_d;
            gap_q      <= gap_d;
`ifdef ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.status   = status_q;
    assign bus.snd_en   = snd_en_q;
    assign bus.snd_note = snd_note_q;
    assign bus.snd_oct  = snd_oct_q;
    assign bus.snd_len  = snd_len_q;
endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: scoreboard bench for sound_arbiter. Expected grants and
// completion statuses are queued as stimulus is driven and popped by a monitor
// when the arbiter pulses gnt or done.
module tb_sound_arbiter;
    localparam int NR   = 4;
    localparam int NB   = 3;
    localparam int OB   = 3;
    localparam int LB   = 3;
    localparam int GAP  = 16;
    localparam int MAXC = 60;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sound_arbiter_if #(.NUM_REQ(NR), .NOTE_BITS(NB), .OCT_BITS(OB), .LEN_BITS(LB)) bus ();

    sound_arbiter #(
        .NUM_REQ(NR), .NOTE_BITS(NB), .OCT_BITS(OB), .LEN_BITS(LB),
        .GAP_CYCLES(GAP), .MAX_CYCLES(MAXC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int owner;
        int note;
        int oct;
        int len;
    } gexp_t;

    int    n_vec = 0;
    int    n_bad = 0;
    gexp_t gq[$];
    int    dq[$];
    int    fnote[NR];
    int    foct[NR];
    int    flen[NR];
    gexp_t mon_e;
    int    mon_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int i, input int n, input int o, input int l);
        fnote[i] = n;
        foct[i]  = o;
        flen[i]  = l;
        bus.note_in[i*NB +: NB] = NB'(n);
        bus.oct_in[i*OB +: OB]  = OB'(o);
        bus.len_in[i*LB +: LB]  = LB'(l);
    endtask

    task automatic push_gnt(input int i);
        gexp_t e;
        e.owner = i;
        e.note  = fnote[i];
        e.oct   = foct[i];
        e.len   = flen[i];
        gq.push_back(e);
    endtask

    task automatic wait_gnt(input string tag, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.gnt == '0 && cyc < 200);
        chk({tag, "_gnt_seen"}, 32'(bus.gnt != '0), 1);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.done && cyc < 300);
        chk({tag, "_done_seen"}, 32'(bus.done), 1);
    endtask

    task automatic wait_idle(input string tag, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.busy && cyc < 300);
        chk({tag, "_idle_seen"}, 32'(bus.busy), 0);
    endtask

    task automatic play(input int drop, input int len);
        repeat (drop) tick();
        bus.snd_over = 1'b0;
        repeat (len) tick();
        bus.snd_over = 1'b1;
    endtask

    // Monitor: every gnt/done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.gnt != '0) begin
                if (gq.size() == 0) begin
                    chk("unexp_gnt", 32'(bus.gnt), 0);
                end else begin
                    mon_e = gq.pop_front();
                    chk("gnt_onehot", 32'(bus.gnt), 32'(1) << mon_e.owner);
                    chk("gnt_owner", 32'(bus.owner), mon_e.owner);
                    chk("gnt_note", 32'(bus.snd_note), mon_e.note);
                    chk("gnt_oct", 32'(bus.snd_oct), mon_e.oct);
                    chk("gnt_len", 32'(bus.snd_len), mon_e.len);
                    chk("gnt_snd_en", 32'(bus.snd_en), 1);
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) begin
                    chk("unexp_done", 32'(bus.done), 0);
                end else begin
                    mon_s = dq.pop_front();
                    chk("done_status", 32'(bus.status), mon_s);
                    chk("done_snd_en", 32'(bus.snd_en), 0);
                    chk("done_busy", 32'(bus.busy), 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int exp_own[3];
        bus.req      = '0;
        bus.note_in  = '0;
        bus.oct_in   = '0;
        bus.len_in   = '0;
        bus.abort    = 1'b0;
        bus.snd_over = 1'b1;
        for (int i = 0; i < NR; i++) set_fields(i, i + 1, 7 - i, i + 2);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_snd_en", 32'(bus.snd_en), 0);
        chk("rst_fields", {bus.snd_note, bus.snd_oct, bus.snd_len, bus.owner, bus.status}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: single note
        set_fields(0, 3, 4, 1);
        bus.req = 4'b0001;
        push_gnt(0);
        dq.push_back(0);
        tick();
        chk("t1_gnt_lat", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        play(2, 50);
        wait_done("t1", cyc);
        chk("t1_done_lat", cyc, 1);
        wait_idle("t1", cyc);
        chk("t1_gap", cyc, GAP);
        set_fields(0, 1, 7, 2);

        // 2: contention with req=1011 held for three notes
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`ifdef ROUND_ROBIN_EN
        exp_own = '{0, 1, 3};
`else
        exp_own = '{0, 0, 0};
`endif
        for (int j = 0; j < 3; j++) begin
            push_gnt(exp_own[j]);
            dq.push_back(0);
        end
        bus.req = 4'b1011;
        for (int j = 0; j < 3; j++) begin
            wait_gnt("t2", cyc);
            chk("t2_owner", 32'(bus.owner), exp_own[j]);
            if (j == 2) bus.req = '0;
            play(2, 10);
            wait_done("t2", cyc);
            wait_idle("t2", cyc);
            chk("t2_gap", cyc, GAP);
        end

        // 3: abort in PLAY, then abort held through GAP and IDLE is ignored
        bus.req = 4'b0010;
        push_gnt(1);
        dq.push_back(1);
        wait_gnt("t3", cyc);
        bus.req = '0;
        repeat (2) tick();
        bus.snd_over = 1'b0;
        repeat (10) tick();
        bus.abort = 1'b1;
        tick();
        chk("t3_done", 32'(bus.done), 1);
        chk("t3_snd_en", 32'(bus.snd_en), 0);
        bus.snd_over = 1'b1;
        wait_idle("t3", cyc);
        chk("t3_gap", cyc, GAP);
        repeat (3) tick();
        chk("t3_idle_abort", 32'(bus.busy), 0);
        bus.abort = 1'b0;

        // 4: abort and snd_over rising in the same PLAY cycle
        bus.req = 4'b0100;
        push_gnt(2);
        dq.push_back(0);
        wait_gnt("t4", cyc);
        bus.req = '0;
        repeat (2) tick();
        bus.snd_over = 1'b0;
        repeat (5) tick();
        bus.abort    = 1'b1;
        bus.snd_over = 1'b1;
        tick();
        chk("t4_done", 32'(bus.done), 1);
        bus.abort = 1'b0;
        tick();
        chk("t4_done_pulse", 32'(bus.done), 0);
        wait_idle("t4", cyc);
        chk("t4_gap", cyc, GAP - 1);

        // 5: watchdog with snd_over stuck high
        bus.req = 4'b1000;
        push_gnt(3);
        dq.push_back(2);
        wait_gnt("t5", cyc);
        bus.req = '0;
        wait_done("t5", cyc);
        chk("t5_wdog_lat", cyc, MAXC);
        wait_idle("t5", cyc);
        chk("t5_gap", cyc, GAP);

        // 6: reset in the middle of PLAY
        bus.req = 4'b0010;
        push_gnt(1);
        wait_gnt("t6", cyc);
        bus.req = '0;
        repeat (2) tick();
        bus.snd_over = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", {bus.gnt, bus.busy, bus.done, bus.snd_en}, 0);
        chk("t6_rst_fields", {bus.snd_note, bus.snd_oct, bus.snd_len, bus.owner, bus.status}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        bus.snd_over = 1'b1;
        repeat (3) tick();
        chk("t6_no_done", 32'(bus.done), 0);
        bus.req = 4'b0100;
        push_gnt(2);
        dq.push_back(0);
        tick();
        chk("t6_gnt", 32'(bus.gnt), 32'b0100);
        bus.req = '0;
        play(2, 8);
        wait_done("t6", cyc);
        wait_idle("t6", cyc);
        repeat (2) tick();

        chk("gnt_q_left", gq.size(), 0);
        chk("done_q_left", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
